// File: rtl/drv_segment_scan_if.sv
// Frame input and digit-scan outputs of the 7-segment scan controller.
// The master drives the symbol frame; the slave drives the symbol driver and digit selects.
interface drv_segment_scan_if #(
  parameter int unsigned p_digits = 4
);
  logic                  i_en;
  logic [8*p_digits-1:0] i_val;
  logic [7:0]            o_val;
  logic [p_digits-1:0]   o_dig;
  logic                  o_frame;

  modport master (
    output i_en,
    output i_val,
    input  o_val,
    input  o_dig,
    input  o_frame
  );

  modport slave (
    input  i_en,
    input  i_val,
    output o_val,
    output o_dig,
    output o_frame
  );
endinterface

// File: rtl/drv_segment_scan.sv
// Time-multiplexed 7-segment scan controller: buffers one frame of symbol codes and
// walks the digits, opening each slot with a blanking gap to suppress ghosting.
module drv_segment_scan #(
  parameter int unsigned p_digits      = 4,
  parameter int unsigned p_div         = 50000,
  parameter int unsigned p_blank       = 16,
  parameter bit          p_dig_act_low = 1'b1
) (
  input logic              i_clk,
  input logic              i_rst,
  drv_segment_scan_if.slave bus
);

  localparam int unsigned IdxW = (p_digits > 1) ? $clog2(p_digits) : 1;
  localparam int unsigned CntW = (p_div > 1) ? $clog2(p_div) : 1;

  localparam logic [IdxW-1:0]     IdxLast   = IdxW'(p_digits - 1);
  localparam logic [CntW-1:0]     BlankLast = CntW'(p_blank - 1);
  localparam logic [CntW-1:0]     ShowLast  = CntW'(p_div - p_blank - 1);
  localparam logic [p_digits-1:0] DigOff    = p_dig_act_low ? {p_digits{1'b1}} : '0;

  if (p_digits < 1) begin : g_bad_digits
    $error("drv_segment_scan: p_digits must be at least 1");
  end
  if (p_blank < 1) begin : g_bad_blank
    $error("drv_segment_scan: p_blank must be at least 1");
  end
  if (p_div <= p_blank) begin : g_bad_div
    $error("drv_segment_scan: p_div must exceed p_blank");
  end

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

  state_e                state_q;
  logic [IdxW-1:0]       idx_q;
  logic [CntW-1:0]       cnt_q;
  logic [8*p_digits-1:0] shadow_q;
  logic [7:0]            val_q;
  logic [p_digits-1:0]   dig_q;
  logic                  frame_q;

  logic [IdxW-1:0]     idx_inc;
  logic [7:0]          next_code;
  logic [p_digits-1:0] dig_on;

  always_comb begin
    idx_inc = idx_q + IdxW'(1);
    // Flipping the single selected bit of the inactive pattern gives either polarity.
    dig_on  = DigOff ^ (p_digits'(1) << idx_q);
  end

  // With one digit the shadow is a single byte and the "next digit" path never fires.
  if (p_digits > 1) begin : g_multi
    always_comb begin
      next_code = shadow_q[{idx_inc, 3'b000} +: 8];
    end
  end else begin : g_single
    always_comb begin
      next_code = shadow_q[7:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      val_q    <= '0;
      dig_q    <= DigOff;
      frame_q  <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          dig_q <= DigOff;
          if (bus.i_en) begin
            state_q  <= StBlank;
            idx_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= bus.i_val;
            val_q    <= bus.i_val[7:0];
            frame_q  <= 1'b1;
          end
        end
        StBlank: begin
          if (!bus.i_en) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= DigOff;
          end else if (cnt_q == BlankLast) begin
            state_q <= StShow;
            cnt_q   <= '0;
            dig_q   <= dig_on;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StShow: begin
          // Disable is checked first so it wins over an end-of-slot on the same edge.
          if (!bus.i_en) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= DigOff;
          end else if (cnt_q == ShowLast) begin
            state_q <= StBlank;
            cnt_q   <= '0;
            dig_q   <= DigOff;
            if (idx_q == IdxLast) begin
              idx_q    <= '0;
              shadow_q <= bus.i_val;
              val_q    <= bus.i_val[7:0];
              frame_q  <= 1'b1;
            end else begin
              idx_q <= idx_inc;
              val_q <= next_code;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          idx_q   <= '0;
          cnt_q   <= '0;
          dig_q   <= DigOff;
        end
      endcase
    end
  end

  assign bus.o_val   = val_q;
  assign bus.o_dig   = dig_q;
  assign bus.o_frame = frame_q;

endmodule

// File: tb/tb_drv_segment_scan.sv
// Directed bench for drv_segment_scan: a 4-digit active-low instance (div 8, blank 2)
// and a 1-digit active-high instance; inputs change and outputs are sampled on negedges.
module tb_drv_segment_scan;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  drv_segment_scan_if #(.p_digits(4)) bus1 ();
  drv_segment_scan_if #(.p_digits(1)) bus2 ();

  drv_segment_scan #(
    .p_digits     (4),
    .p_div        (8),
    .p_blank      (2),
    .p_dig_act_low(1'b1)
  ) u_dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus1)
  );

  drv_segment_scan #(
    .p_digits     (1),
    .p_div        (8),
    .p_blank      (2),
    .p_dig_act_low(1'b0)
  ) u_var (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full 8-cycle slot of the 4-digit instance, starting at the first blank cycle.
  task automatic slot(input string tag, input logic [7:0] v, input logic [3:0] on,
                      input logic fr);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk({tag, " dig"}, bus1.o_dig, (c < 2) ? 4'hF : on);
      chk({tag, " val"}, bus1.o_val, v);
      chk({tag, " frame"}, bus1.o_frame, (c == 0) ? 1'b1 & fr : 1'b0);
    end
  endtask

  // One slot of the 1-digit instance; nv is applied to i_val mid-slot.
  task automatic slot2(input string tag, input logic [7:0] v, input logic [7:0] nv);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk({tag, " dig"}, bus2.o_dig, (c < 2) ? 1'b0 : 1'b1);
      chk({tag, " val"}, bus2.o_val, v);
      chk({tag, " frame"}, bus2.o_frame, (c == 0) ? 1'b1 : 1'b0);
      if (c == 3) bus2.i_val = nv;
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus1.i_en  = 1'b0;
    bus1.i_val = '0;
    bus2.i_en  = 1'b0;
    bus2.i_val = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst dig", bus1.o_dig, 4'hF);
    chk("rst val", bus1.o_val, 8'h00);
    chk("rst frame", bus1.o_frame, 1'b0);
    chk("rst var dig", bus2.o_dig, 1'b0);
    chk("rst var val", bus2.o_val, 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle dig", bus1.o_dig, 4'hF);
    chk("idle val", bus1.o_val, 8'h00);
    chk("idle frame", bus1.o_frame, 1'b0);

    // Basic scan, two frames; mid-frame update during digit-1 show of the second
    bus1.i_val = 32'h03020100;
    bus1.i_en  = 1'b1;
    slot("f1d0", 8'h00, 4'b1110, 1'b1);
    slot("f1d1", 8'h01, 4'b1101, 1'b0);
    slot("f1d2", 8'h02, 4'b1011, 1'b0);
    slot("f1d3", 8'h03, 4'b0111, 1'b0);
    slot("f2d0", 8'h00, 4'b1110, 1'b1);
    slot("f2d1", 8'h01, 4'b1101, 1'b0);
    bus1.i_val = 32'h0F0E0D0C;
    slot("f2d2", 8'h02, 4'b1011, 1'b0);
    slot("f2d3", 8'h03, 4'b0111, 1'b0);
    slot("f3d0", 8'h0C, 4'b1110, 1'b1);
    slot("f3d1", 8'h0D, 4'b1101, 1'b0);
    slot("f3d2", 8'h0E, 4'b1011, 1'b0);
    slot("f3d3", 8'h0F, 4'b0111, 1'b0);

    // Disable during digit-2 show, then re-enable
    slot("f4d0", 8'h0C, 4'b1110, 1'b1);
    slot("f4d1", 8'h0D, 4'b1101, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("f4d2 dig", bus1.o_dig, (c < 2) ? 4'hF : 4'b1011);
      chk("f4d2 val", bus1.o_val, 8'h0E);
    end
    bus1.i_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("dis dig", bus1.o_dig, 4'hF);
      chk("dis frame", bus1.o_frame, 1'b0);
      chk("dis val", bus1.o_val, 8'h0E);
    end
    bus1.i_en = 1'b1;
    slot("f5d0", 8'h0C, 4'b1110, 1'b1);

    // Synchronous reset during digit-3 show
    slot("f5d1", 8'h0D, 4'b1101, 1'b0);
    slot("f5d2", 8'h0E, 4'b1011, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("f5d3 dig", bus1.o_dig, (c < 2) ? 4'hF : 4'b0111);
      chk("f5d3 val", bus1.o_val, 8'h0F);
    end
    rst = 1'b1;
    #2;
    chk("rst pre-edge dig", bus1.o_dig, 4'b0111);
    chk("rst pre-edge val", bus1.o_val, 8'h0F);
    @(negedge clk);
    chk("rst mid dig", bus1.o_dig, 4'hF);
    chk("rst mid val", bus1.o_val, 8'h00);
    chk("rst mid frame", bus1.o_frame, 1'b0);
    rst = 1'b0;
    slot("f6d0", 8'h0C, 4'b1110, 1'b1);
    bus1.i_en = 1'b0;

    // Single-digit, active-high variant
    bus2.i_val = 8'hA5;
    bus2.i_en  = 1'b1;
    slot2("v0", 8'hA5, 8'h5A);
    slot2("v1", 8'h5A, 8'h5A);
    slot2("v2", 8'h5A, 8'h33);
    slot2("v3", 8'h33, 8'h33);
    bus2.i_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
